accum_frame: RTL and testbench
==============================

# accum_frame

Sequential signed frame accumulator that sits downstream of the team's N-bit ripple-carry adder stage. It accepts a stream of signed operands over a valid/ready handshake and drives the adder with the running total and the incoming operand. It captures the adder's sum and overflow into its accumulator register, then presents one frame result per `in_last` beat on a valid/ready output. The adder stays a separate combinational instance; this block owns all state.

## Interface
- `N`, default 32: operand, accumulator and adder width (≥ 2).
- `CNT_W`, default 8: width of the beat counter.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `clr`  in  1  — synchronous clear, highest priority.
- `in_valid`  in  1  — operand beat valid.
- `in_ready`  out  1  — block can accept a beat.
- `in_data`  in  N  — signed operand.
- `in_last`  in  1  — beat is the final one of the frame.
- `add_a`  out  N  — adder operand A; always equals the accumulator register.
- `add_b`  out  N  — adder operand B; always equals `in_data`.
- `add_cin`  out  1  — adder carry-in; constant 0.
- `add_sum`  in  N  — adder sum.
- `add_ovf`  in  1  — adder signed-overflow flag.
- `out_valid`  out  1  — frame result valid.
- `out_ready`  in  1  — consumer accepts the result.
- `out_data`  out  N  — signed frame total.
- `out_ovf`  out  1  — sticky: one or more beats in the frame overflowed.
- `out_count`  out  CNT_W  — beats in the frame; saturates at 2^CNT_W−1.

## Operation
- States are IDLE, ACCUM and DONE.
- Reset value of every register is 0: accumulator, count, sticky overflow, `out_data`, `out_ovf`, `out_count`, `out_valid`. The FSM resets to IDLE.
- `in_ready` = 1 in IDLE and ACCUM, 0 in DONE.
- `out_valid` = 1 only in DONE.
- Beat accepted = `in_valid & in_ready & ~clr`. On an accepted beat:
  - acc ← next value (see Configuration).
  - count ← count+1, saturating.
  - sticky ← sticky | `add_ovf`.
- IDLE → ACCUM on an accepted beat with `in_last`=0.
- IDLE or ACCUM → DONE on an accepted beat with `in_last`=1. On that edge:
  - `out_data` ← next acc value.
  - `out_ovf` ← sticky | `add_ovf`.
  - `out_count` ← count+1, saturating.
- DONE → IDLE when `out_ready`=1. On that edge acc, count and sticky clear to 0. Output registers hold their last values but are no longer valid.
- Output registers are stable while `out_valid`=1.
- `clr`=1 in any state:
  - Next state is IDLE.
  - acc, count, sticky and `out_valid` clear to 0.
  - A same-cycle input beat is discarded.
  - A pending output is dropped even if `out_ready`=1.
- A single-beat frame (first beat has `in_last`=1) goes IDLE → DONE with `out_count`=1.
- Arithmetic is two's complement, N bits. `add_ovf` is the adder's carry(N−1) XOR carry(N).
- Asynchronous reset during any state forces IDLE and the reset values above immediately.

## Timing
- Combinational path: `in_data` → `add_b` → adder → `add_sum`/`add_ovf` → acc D input, within one cycle. There are no other combinational paths from inputs to outputs.
- Throughput is one beat per cycle in IDLE/ACCUM.
- Latency: if the last beat is accepted at edge t, `out_valid`=1 from edge t, i.e. visible in the cycle after the beat.
- The earliest next beat is accepted in the cycle after the output handshake, giving 1 bubble cycle per frame.
- `in_ready` and `out_valid` are registered-state decodes, not dependent on `in_valid` or `out_ready`.

## Configuration
- Macro `ACCUM_FRAME_SAT_EN`.
- Defined: when `add_ovf`=1, acc takes a saturated value instead of `add_sum`.
  - `in_data` MSB = 0 saturates to +(2^(N−1)−1).
  - `in_data` MSB = 1 saturates to −2^(N−1).
  - The sticky flag still sets.
- Undefined: acc ← `add_sum` always (wrap-around). The sticky flag behaves identically.

## Test plan
- Reset with `rst_n` held low, then released → `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0, `out_ovf`=0, `add_cin`=0.
- N=8, beats 10, 20, −5 (last) back-to-back → `out_valid`=1 the cycle after the last beat, `out_data`=25, `out_count`=3, `out_ovf`=0.
- N=8, beats 100, 50 (last):
  - Without macro → `out_data`=−106 (0x96), `out_ovf`=1.
  - With macro → `out_data`=127, `out_ovf`=1.
- N=8, beats −100, −100 (last):
  - Without macro → `out_data`=56, `out_ovf`=1.
  - With macro → `out_data`=−128, `out_ovf`=1.
- Backpressure: result pending, `out_ready`=0 for 5 cycles with `in_valid`=1 → `out_valid` held, outputs unchanged, `in_ready`=0, no beats consumed. `out_ready`=1 → next cycle IDLE and `in_ready`=1.
- `clr` asserted after beats 3, 4, together with an offered beat 9 → state IDLE, beat 9 dropped. Then single beat 7 with `in_last` → `out_data`=7, `out_count`=1, `out_ovf`=0.

Source files
------------

// File: rtl/accum_frame.sv
// accum_frame: signed frame accumulator driving an external N-bit adder.
// Ports: clk/rst_n/clr, in_* beat handshake, add_* adder link, out_* frame result.
// Optional: ACCUM_FRAME_SAT_EN saturates acc on adder overflow.
module accum_frame #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_sum,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stk_q, stk_d;
  logic [N-1:0]     odata_q, odata_d;
  logic             oovf_q, oovf_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;

  logic             beat;
  logic [N-1:0]     acc_nx;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign add_cin   = 1'b0;
  assign out_data  = odata_q;
  assign out_ovf   = oovf_q;
  assign out_count = ocnt_q;

  assign beat    = in_valid & in_ready & ~clr;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef ACCUM_FRAME_SAT_EN
  // Overflow only occurs when both operands share a sign,
  // so the operand MSB picks the saturation rail.
  always_comb begin
    acc_nx = add_sum;
    if (add_ovf)
      acc_nx = in_data[N-1] ? {1'b1, {(N-1){1'b0}}}
                            : {1'b0, {(N-1){1'b1}}};
  end
`else
  assign acc_nx = add_sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    stk_d   = stk_q;
    odata_d = odata_q;
    oovf_d  = oovf_q;
    ocnt_d  = ocnt_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      stk_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (beat) begin
            acc_d = acc_nx;
            cnt_d = cnt_inc;
            stk_d = stk_q | add_ovf;
            if (in_last) begin
              state_d = DONE;
              odata_d = acc_nx;
              oovf_d  = stk_q | add_ovf;
              ocnt_d  = cnt_inc;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            stk_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      stk_q   <= 1'b0;
      odata_q <= '0;
      oovf_q  <= 1'b0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      stk_q   <= stk_d;
      odata_q <= odata_d;
      oovf_q  <= oovf_d;
      ocnt_q  <= ocnt_d;
    end
  end

endmodule

// File: tb/tb_accum_frame.sv
// tb_accum_frame: directed bench for accum_frame at N=8.
// Holds a behavioural adder standing in for the ripple-carry stage.
module tb_accum_frame;

  localparam int N     = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic [N-1:0]     add_a;
  logic [N-1:0]     add_b;
  logic             add_cin;
  logic [N-1:0]     add_sum;
  logic             add_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  accum_frame #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_ovf   (add_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  // Adder stand-in: signed overflow when like-signed operands
  // produce a result of the other sign.
  always_comb begin
    add_sum = add_a + add_b + {{(N-1){1'b0}}, add_cin};
    add_ovf = (add_a[N-1] == add_b[N-1]) &&
              (add_sum[N-1] != add_a[N-1]);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [N-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_add_cin", 32'(add_cin), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // 10 + 20 - 5
    beat(8'd10, 1'b0);
    check("t1_add_a", 32'(add_a), 32'd10);
    in_data = 8'd20;
    #1;
    check("t1_add_b", 32'(add_b), 32'd20);
    beat(8'd20, 1'b0);
    beat(8'hFB, 1'b1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_ready", 32'(in_ready), 32'd0);
    check("t1_data", 32'(out_data), 32'd25);
    check("t1_count", 32'(out_count), 32'd3);
    check("t1_ovf", 32'(out_ovf), 32'd0);
    ack();
    check("t1_ack_valid", 32'(out_valid), 32'd0);
    check("t1_ack_ready", 32'(in_ready), 32'd1);
    check("t1_hold_data", 32'(out_data), 32'd25);
    check("t1_acc_clr", 32'(add_a), 32'd0);

    // 100 + 50 overflows positive
    beat(8'd100, 1'b0);
    beat(8'd50, 1'b1);
`ifdef ACCUM_FRAME_SAT_EN
    check("t2_data", 32'(out_data), 32'd127);
`else
    check("t2_data", 32'(out_data), 32'h96);
`endif
    check("t2_ovf", 32'(out_ovf), 32'd1);
    check("t2_count", 32'(out_count), 32'd2);
    ack();

    // -100 + -100 overflows negative
    beat(8'h9C, 1'b0);
    beat(8'h9C, 1'b1);
`ifdef ACCUM_FRAME_SAT_EN
    check("t3_data", 32'(out_data), 32'h80);
`else
    check("t3_data", 32'(out_data), 32'd56);
`endif
    check("t3_ovf", 32'(out_ovf), 32'd1);
    ack();

    // sticky flag must not leak into a clean frame
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b1);
    check("t4_data", 32'(out_data), 32'd3);
    check("t4_ovf", 32'(out_ovf), 32'd0);

    // backpressure with input offered
    in_valid = 1'b1;
    in_data  = 8'd55;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_data", 32'(out_data), 32'd3);
      check("bp_count", 32'(out_count), 32'd2);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check("bp_rel_valid", 32'(out_valid), 32'd0);
    check("bp_rel_ready", 32'(in_ready), 32'd1);
    check("bp_rel_acc", 32'(add_a), 32'd0);
    step();
    check("bp_no_beat", 32'(add_a), 32'd0);

    // clear mid-frame drops the offered beat
    beat(8'd3, 1'b0);
    beat(8'd4, 1'b0);
    check("clr_pre_acc", 32'(add_a), 32'd7);
    clr = 1'b1;
    beat(8'd9, 1'b0);
    clr = 1'b0;
    check("clr_acc", 32'(add_a), 32'd0);
    check("clr_ready", 32'(in_ready), 32'd1);
    check("clr_valid", 32'(out_valid), 32'd0);
    beat(8'd7, 1'b1);
    check("clr_data", 32'(out_data), 32'd7);
    check("clr_count", 32'(out_count), 32'd1);
    check("clr_ovf", 32'(out_ovf), 32'd0);

    // clear drops a pending result despite out_ready
    clr       = 1'b1;
    out_ready = 1'b1;
    step();
    clr       = 1'b0;
    out_ready = 1'b0;
    check("clr_done_valid", 32'(out_valid), 32'd0);
    check("clr_done_ready", 32'(in_ready), 32'd1);

    // beat counter saturates at 255
    for (int i = 0; i < 299; i++) beat(8'd0, 1'b0);
    beat(8'd5, 1'b1);
    check("sat_count", 32'(out_count), 32'd255);
    check("sat_data", 32'(out_data), 32'd5);
    ack();

    // async reset mid-frame
    beat(8'd11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_acc", 32'(add_a), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
